// File: rtl/cache_axi_arbiter_if.sv
// cache_axi_arbiter_if
//   Bundles the cache-side request/response signals and the bridge-side
//   command/data signals of the cache-to-bridge arbiter.
//   master : arbiter view. It takes cache requests and bridge responses, and
//            drives cache responses and bridge commands.
//   slave  : environment view. This covers the caches, the bridge and flush.
interface cache_axi_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
);
  logic              flush;
  // ICache read port
  logic              i_rreq;
  logic [ADDR_W-1:0] i_raddr;
  logic [LEN_W-1:0]  i_rlen;
  logic [ADDR_W-1:0] i_rdata;
  logic              i_rvalid;
  logic              i_rdone;
  // DCache read port
  logic              d_rreq;
  logic [ADDR_W-1:0] d_raddr;
  logic [LEN_W-1:0]  d_rlen;
  logic [3:0]        d_rsel;
  logic [ADDR_W-1:0] d_rdata;
  logic              d_rvalid;
  logic              d_rdone;
  // DCache writeback port
  logic              d_wreq;
  logic [ADDR_W-1:0] d_waddr;
  logic [LEN_W-1:0]  d_wlen;
  logic [3:0]        d_wsel;
  logic [ADDR_W-1:0] d_wdata;
  logic              d_wnext;
  logic              d_wdone;
  // Bridge command side
  logic              b_ce;
  logic              b_ren;
  logic              b_wen;
  logic [ADDR_W-1:0] b_raddr;
  logic [ADDR_W-1:0] b_waddr;
  logic [ADDR_W-1:0] b_wdata;
  logic [3:0]        b_rsel;
  logic [3:0]        b_wsel;
  logic [LEN_W-1:0]  b_rlen;
  logic [LEN_W-1:0]  b_wlen;
  logic              b_wlast;
  // Bridge response side
  logic [ADDR_W-1:0] b_rdata;
  logic              b_rvalid;
  logic              b_rlast;
  logic              b_wresp;
  logic              b_bvalid;

  modport master (
    input  flush,
    input  i_rreq, i_raddr, i_rlen,
    output i_rdata, i_rvalid, i_rdone,
    input  d_rreq, d_raddr, d_rlen, d_rsel,
    output d_rdata, d_rvalid, d_rdone,
    input  d_wreq, d_waddr, d_wlen, d_wsel, d_wdata,
    output d_wnext, d_wdone,
    output b_ce, b_ren, b_wen, b_raddr, b_waddr, b_wdata,
    output b_rsel, b_wsel, b_rlen, b_wlen, b_wlast,
    input  b_rdata, b_rvalid, b_rlast, b_wresp, b_bvalid
  );

  modport slave (
    output flush,
    output i_rreq, i_raddr, i_rlen,
    input  i_rdata, i_rvalid, i_rdone,
    output d_rreq, d_raddr, d_rlen, d_rsel,
    input  d_rdata, d_rvalid, d_rdone,
    output d_wreq, d_waddr, d_wlen, d_wsel, d_wdata,
    input  d_wnext, d_wdone,
    input  b_ce, b_ren, b_wen, b_raddr, b_waddr, b_wdata,
    input  b_rsel, b_wsel, b_rlen, b_wlen, b_wlast,
    output b_rdata, b_rvalid, b_rlast, b_wresp, b_bvalid
  );
endinterface

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter
//   Grants a single bridge (AXI-style burst) to one of three requesters:
//   - ICache read
//   - DCache read
//   - DCache writeback
//   The writeback always wins. The two reads alternate round-robin.
//   Ports:
//   - clk : clock.
//   - rst : synchronous reset, active-high.
//   - bus : cache_axi_arbiter_if.master. This carries flush, the cache
//           request/response ports and the bridge command/response ports.
module cache_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input logic                clk,
  input logic                rst,
  cache_axi_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD_I, RD_D, WR} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_last_rd, w_last_rd_nxt;   // 0: ICache read last, 1: DCache
  logic [LEN_W-1:0]  r_cnt;                      // accepted write beats
  logic              r_ce, r_ren, r_wen;
  logic [ADDR_W-1:0] r_raddr, r_waddr;
  logic [LEN_W-1:0]  r_rlen, r_wlen;
  logic [3:0]        r_rsel, r_wsel;

  logic w_rd_last, w_raw, w_d_rd_ok;

  assign w_rd_last = bus.b_rvalid & bus.b_rlast;
  // A DCache read to the line being written back must wait for the writeback.
  assign w_raw     = bus.d_wreq & bus.d_rreq & (bus.d_raddr == bus.d_waddr);
  assign w_d_rd_ok = bus.d_rreq & ~w_raw;

  always_comb begin
    w_state_nxt   = r_state;
    w_last_rd_nxt = r_last_rd;
    case (r_state)
      IDLE: begin
        if (!bus.flush) begin
          if (bus.d_wreq)                  w_state_nxt = WR;
          else if (bus.i_rreq && w_d_rd_ok) w_state_nxt = r_last_rd ? RD_I : RD_D;
          else if (bus.i_rreq)             w_state_nxt = RD_I;
          else if (w_d_rd_ok)              w_state_nxt = RD_D;
        end
      end
      // An aborted read still consumes that requester's round-robin turn.
      RD_I: if (bus.flush || w_rd_last) begin
        w_state_nxt   = IDLE;
        w_last_rd_nxt = 1'b0;
      end
      RD_D: if (bus.flush || w_rd_last) begin
        w_state_nxt   = IDLE;
        w_last_rd_nxt = 1'b1;
      end
      WR: if (bus.flush || bus.b_bvalid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last_rd <= 1'b1;
      r_cnt     <= '0;
      r_ce      <= 1'b0;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_raddr   <= '0;
      r_waddr   <= '0;
      r_rlen    <= '0;
      r_wlen    <= '0;
      r_rsel    <= '0;
      r_wsel    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_last_rd <= w_last_rd_nxt;
      r_ce      <= 1'b0;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      if (r_state == IDLE) begin
        // Command is registered on the grant edge, so b_ce is a 1-cycle pulse.
        case (w_state_nxt)
          WR: begin
            r_ce    <= 1'b1;
            r_wen   <= 1'b1;
            r_waddr <= bus.d_waddr;
            r_wlen  <= bus.d_wlen;
            r_wsel  <= bus.d_wsel;
            r_cnt   <= '0;
          end
          RD_I: begin
            r_ce    <= 1'b1;
            r_ren   <= 1'b1;
            r_raddr <= bus.i_raddr;
            r_rlen  <= bus.i_rlen;
            r_rsel  <= 4'hF;          // ICache fetches full words
          end
          RD_D: begin
            r_ce    <= 1'b1;
            r_ren   <= 1'b1;
            r_raddr <= bus.d_raddr;
            r_rlen  <= bus.d_rlen;
            r_rsel  <= bus.d_rsel;
          end
          default: ;
        endcase
      end else if (r_state == WR && bus.b_wresp) begin
        r_cnt <= r_cnt + LEN_W'(1);
      end
    end
  end

  // Bridge command outputs
  assign bus.b_ce    = r_ce;
  assign bus.b_ren   = r_ren;
  assign bus.b_wen   = r_wen;
  assign bus.b_raddr = r_raddr;
  assign bus.b_waddr = r_waddr;
  assign bus.b_rlen  = r_rlen;
  assign bus.b_wlen  = r_wlen;
  assign bus.b_rsel  = r_rsel;
  assign bus.b_wsel  = r_wsel;

  // Read beats go only to the granted requester.
  // Done is suppressed when the burst is being flushed.
  assign bus.i_rdata  = (r_state == RD_I) ? bus.b_rdata : '0;
  assign bus.i_rvalid = (r_state == RD_I) & bus.b_rvalid;
  assign bus.i_rdone  = (r_state == RD_I) & w_rd_last & ~bus.flush;
  assign bus.d_rdata  = (r_state == RD_D) ? bus.b_rdata : '0;
  assign bus.d_rvalid = (r_state == RD_D) & bus.b_rvalid;
  assign bus.d_rdone  = (r_state == RD_D) & w_rd_last & ~bus.flush;

  // Writeback data path.
  // b_wlast uses the length latched at grant, which is d_wlen held for the burst.
  assign bus.b_wdata  = (r_state == WR) ? bus.d_wdata : '0;
  assign bus.d_wnext  = (r_state == WR) & bus.b_wresp;
  assign bus.b_wlast  = (r_state == WR) & (r_cnt == r_wlen);
  assign bus.d_wdone  = (r_state == WR) & bus.b_bvalid & ~bus.flush;

endmodule

// File: doc/cache_axi_arbiter.md
CACHE_AXI_ARBITER -- requirements
Module: cache_axi_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- ADDR_W, 32, address/data width.
- LEN_W, 8, burst length field width (AXI arlen/awlen encoding, beats-1).
REQ-002 SHALL have clock and reset: reset rst, synchronous, active-high; clock clk.
REQ-003 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- rst  in  1  sync reset, active-high.
- flush  in  1  pipeline flush; aborts the current grant.
- i_rreq  in  1  ICache read request, level, held until i_rdone.
- i_raddr  in  32  ICache burst start address.
- i_rlen  in  8  ICache burst length.
- i_rdata  out  32  ICache read beat.
- i_rvalid  out  1  ICache beat valid.
- i_rdone  out  1  ICache final beat (1-cycle pulse).
- d_rreq  in  1  DCache read request, level.
- d_raddr  in  32  DCache read address.
- d_rlen  in  8  DCache read length.
- d_rsel  in  4  DCache byte select.
- d_rdata  out  32  DCache read beat.
- d_rvalid  out  1  DCache beat valid.
- d_rdone  out  1  DCache final read beat.
- d_wreq  in  1  DCache writeback request, level.
- d_waddr  in  32  writeback address.
- d_wlen  in  8  writeback length.
- d_wsel  in  4  writeback byte strobes.
- d_wdata  in  32  current write beat.
- d_wnext  out  1  write beat accepted; DCache advances d_wdata.
- d_wdone  out  1  writeback complete (1-cycle pulse).
- b_ce, b_ren, b_wen  out  1 each  bridge enable and read/write command.
- b_raddr, b_waddr, b_wdata  out  32 each  bridge address/data.
- b_rsel, b_wsel  out  4 each  bridge byte selects.
- b_rlen, b_wlen  out  8 each  bridge burst lengths.
- b_wlast  out  1  last write beat.
- b_rdata  in  32  bridge read data.
- b_rvalid, b_rlast  in  1 each  bridge beat valid / last beat.
- b_wresp  in  1  bridge write beat accepted.
- b_bvalid  in  1  bridge write response.

Function
REQ-004 SHALL implement FSM states IDLE, RD_I, RD_D, WR; exactly one grant at a time.
REQ-005 In IDLE, priority SHALL be d_wreq first, then reads round-robin via 1-bit last_rd pointer (0=I, 1=D); the non-last requester wins when both read requests are pending.
REQ-006 On leaving IDLE, b_ce SHALL pulse for exactly 1 cycle with b_ren (RD_*) or b_wen (WR), plus the granted address, length and sel registered from the requester.
REQ-007 Read beats SHALL be routed combinationally: x_rdata=b_rdata, x_rvalid=b_rvalid only for the granted requester; the other side's rvalid SHALL be 0.
REQ-008 x_rdone SHALL equal b_rvalid&b_rlast in the granted RD state; the FSM SHALL return to IDLE the next cycle and update last_rd.
REQ-009 In WR, b_wdata=d_wdata and d_wnext=b_wresp; an 8-bit beat counter SHALL count accepted beats; b_wlast SHALL be 1 when counter==d_wlen.
REQ-010 WR SHALL exit to IDLE on b_bvalid, pulsing d_wdone that cycle.
REQ-011 A d_rreq whose address matches a same-cycle d_wreq SHALL be served only after d_wdone, preserving RAW order.
REQ-012 A requester dropping its request mid-grant SHALL be ignored; the grant completes on bridge done.
REQ-013 Back-to-back grants SHALL spend at least 1 cycle in IDLE between bursts.
REQ-014 flush SHALL force IDLE next cycle; no done pulses SHALL be issued for the aborted burst.

Reset
REQ-015 On rst: state=IDLE, last_rd=1 (ICache wins first), beat counter=0, all outputs 0.

Verification
REQ-016 Bench SHALL cover:
- i_rreq only, i_rlen=7 -> single b_ce/b_ren pulse, 8 i_rvalid beats, i_rdone on beat 8, d_rvalid stays 0.
- i_rreq and d_rreq together after reset -> ICache granted first, then DCache; reversed on the next collision.
- d_wreq and d_rreq, same address 0x1C000100 -> WR first; b_ren only after d_wdone.
- d_wlen=3 with b_wresp stalls -> 4 d_wnext pulses, b_wlast on the 4th, d_wdone on b_bvalid.
- flush during RD_D beat 2 -> IDLE next cycle, no d_rdone, pending i_rreq granted afterwards.
- rst mid-WR -> all outputs 0 and IDLE the next cycle.
